trig_input_cond: RTL and testbench

TRIG_INPUT_COND -- requirements
Module: trig_input_cond

---
 rtl/trig_input_cond.sv | 95 +++++++++
 tb/tb_trig_input_cond.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/trig_input_cond.sv
// trig_input_cond: synchronises coax trigger inputs, detects rising edges and forms an M-of-N coincidence trigger.
// Ports: clk/nrst (sync, active-low); coax_in raw async inputs; chan_mask enables channels;
//   coinc_window window length in ticks; multiplicity required distinct channels (0 means 1);
//   busy downstream dead/firing; trig_req one-cycle request; hit_pattern last accepted channels;
//   trig_count accepted triggers; veto_count coincidences met while busy (both saturating).
module trig_input_cond #(
  parameter int NCH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [NCH-1:0]   coax_in,
  input  logic [NCH-1:0]   chan_mask,
  input  logic [7:0]       coinc_window,
  input  logic [4:0]       multiplicity,
  input  logic             busy,
  output logic             trig_req,
  output logic [NCH-1:0]   hit_pattern,
  output logic [31:0]      trig_count,
  output logic [31:0]      veto_count
);
  localparam int PW = ($clog2(NCH + 1) > 5) ? $clog2(NCH + 1) : 5;
  localparam int AW = $clog2(SYNC_STAGES + 2);
  typedef enum logic [1:0] {IDLE, OPEN, HOLDOFF} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][NCH-1:0] sync_ff;
  logic [NCH-1:0] sync, sync_d, edges, comb_v, acc, acc_n;
  logic [7:0] wcnt, wcnt_n;
  logic [AW-1:0] arm_cnt;
  logic armed, sat, fire, veto;
  logic [PW-1:0] pc, m_eff;
  assign sync = sync_ff[SYNC_STAGES-1];
  // Edges stay blocked until the chain and sync_d have refilled after reset, so an
  // input already high when nrst rises never looks like a fresh rising edge.
  assign armed = arm_cnt == AW'(SYNC_STAGES + 1);
  assign edges = armed ? (sync & ~sync_d & chan_mask) : '0;
  assign comb_v = (state == OPEN) ? (acc | edges) : edges;
  assign m_eff = (multiplicity == 5'd0) ? PW'(1) : PW'(multiplicity);
  assign sat = pc >= m_eff;
  always_comb begin
    pc = '0;
    for (int i = 0; i < NCH; i++) pc = pc + PW'(comb_v[i]);
  end
  always_comb begin
    state_n = state;
    acc_n = acc;
    wcnt_n = wcnt;
    fire = 1'b0;
    veto = 1'b0;
    case (state)
      IDLE: if (|edges) begin
        acc_n = edges;
        wcnt_n = coinc_window;
        fire = sat && !busy;
        veto = sat && busy;
        state_n = sat ? HOLDOFF : (coinc_window != 8'd0) ? OPEN : IDLE;
      end
      OPEN: begin
        acc_n = comb_v;
        fire = sat && !busy;
        veto = sat && busy;
        wcnt_n = wcnt - 8'd1;
        state_n = sat ? HOLDOFF : (wcnt <= 8'd1) ? IDLE : OPEN;
        if (!sat && wcnt <= 8'd1) acc_n = '0;
      end
      HOLDOFF: state_n = ((sync & chan_mask) == '0) ? IDLE : HOLDOFF;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_ff <= '0;
      sync_d <= '0;
      arm_cnt <= '0;
      state <= IDLE;
      acc <= '0;
      wcnt <= '0;
      trig_req <= 1'b0;
      hit_pattern <= '0;
      trig_count <= '0;
      veto_count <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], coax_in};
      sync_d <= sync;
      arm_cnt <= armed ? arm_cnt : arm_cnt + AW'(1);
      state <= state_n;
      acc <= acc_n;
      wcnt <= wcnt_n;
      trig_req <= fire;
      if (fire) hit_pattern <= comb_v;
      if (fire && trig_count != '1) trig_count <= trig_count + 32'd1;
      if (veto && veto_count != '1) veto_count <= veto_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_trig_input_cond.sv
// tb_trig_input_cond: directed self-checking bench for trig_input_cond.
module tb_trig_input_cond;
  logic clk = 1'b0;
  logic nrst;
  logic [15:0] coax_in, chan_mask, hit_pattern;
  logic [7:0] coinc_window;
  logic [4:0] multiplicity;
  logic busy, trig_req;
  logic [31:0] trig_count, veto_count;
  int n_cmp = 0;
  int n_err = 0;
  int cnt, first;

  trig_input_cond #(.NCH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .nrst(nrst), .coax_in(coax_in), .chan_mask(chan_mask),
    .coinc_window(coinc_window), .multiplicity(multiplicity), .busy(busy),
    .trig_req(trig_req), .hit_pattern(hit_pattern), .trig_count(trig_count),
    .veto_count(veto_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run(input int n, output int c, output int f);
    c = 0;
    f = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (trig_req === 1'b1) begin
        c++;
        if (f < 0) f = k;
      end
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0; coax_in = '0; chan_mask = 16'hFFFF; coinc_window = 8'd4;
    multiplicity = 5'd1; busy = 1'b0;
    tick(3);
    n_cmp++; if (trig_req !== 1'b0) begin n_err++; $display("FAIL reset_trig: got %0b want 0", trig_req); end
    n_cmp++; if (hit_pattern !== 16'h0) begin n_err++; $display("FAIL reset_hit: got %h want 0000", hit_pattern); end
    n_cmp++; if (trig_count !== 32'd0) begin n_err++; $display("FAIL reset_tcount: got %0d want 0", trig_count); end
    n_cmp++; if (veto_count !== 32'd0) begin n_err++; $display("FAIL reset_vcount: got %0d want 0", veto_count); end
    nrst = 1'b1;
    tick(5);
  endtask

  task automatic test_single;
    multiplicity = 5'd1; coinc_window = 8'd4;
    coax_in = 16'h0008;
    run(8, cnt, first);
    n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL single_pulses: got %0d want 1", cnt); end
    n_cmp++; if (first !== 3) begin n_err++; $display("FAIL single_latency: got %0d want 3", first); end
    n_cmp++; if (hit_pattern !== 16'h0008) begin n_err++; $display("FAIL single_hit: got %h want 0008", hit_pattern); end
    n_cmp++; if (trig_count !== 32'd1) begin n_err++; $display("FAIL single_tcount: got %0d want 1", trig_count); end
    coax_in = '0;
    tick(5);
  endtask

  task automatic test_window;
    multiplicity = 5'd2; coinc_window = 8'd4;
    coax_in = 16'h0001;
    tick(4);
    coax_in = 16'h0021;
    run(8, cnt, first);
    n_cmp++; if (cnt !== 1 || first !== 3) begin n_err++; $display("FAIL window_gap4: got %0d pulses at %0d want 1 at 3", cnt, first); end
    n_cmp++; if (hit_pattern !== 16'h0021) begin n_err++; $display("FAIL window_hit: got %h want 0021", hit_pattern); end
    coax_in = '0;
    tick(5);
    coax_in = 16'h0001;
    tick(5);
    coax_in = 16'h0021;
    run(10, cnt, first);
    n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL window_gap5: got %0d pulses want 0", cnt); end
    n_cmp++; if (trig_count !== 32'd2) begin n_err++; $display("FAIL window_tcount: got %0d want 2", trig_count); end
    coax_in = '0;
    tick(10);
  endtask

  task automatic test_busy;
    multiplicity = 5'd2; busy = 1'b1;
    coax_in = 16'h0006;
    run(8, cnt, first);
    n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL busy_pulses: got %0d want 0", cnt); end
    n_cmp++; if (veto_count !== 32'd1) begin n_err++; $display("FAIL busy_vcount: got %0d want 1", veto_count); end
    n_cmp++; if (trig_count !== 32'd2) begin n_err++; $display("FAIL busy_tcount: got %0d want 2", trig_count); end
    n_cmp++; if (hit_pattern !== 16'h0021) begin n_err++; $display("FAIL busy_hit: got %h want 0021", hit_pattern); end
    coax_in = '0; busy = 1'b0;
    tick(5);
  endtask

  task automatic test_held;
    multiplicity = 5'd1;
    coax_in = 16'h0080;
    run(50, cnt, first);
    n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL held_pulses: got %0d want 1", cnt); end
    n_cmp++; if (hit_pattern !== 16'h0080) begin n_err++; $display("FAIL held_hit: got %h want 0080", hit_pattern); end
    coax_in = '0;
    tick(4);
    coax_in = 16'h0080;
    run(8, cnt, first);
    n_cmp++; if (cnt !== 1 || first !== 3) begin n_err++; $display("FAIL held_retrig: got %0d pulses at %0d want 1 at 3", cnt, first); end
    n_cmp++; if (trig_count !== 32'd4) begin n_err++; $display("FAIL held_tcount: got %0d want 4", trig_count); end
    coax_in = '0;
    tick(5);
  endtask

  task automatic test_mask;
    chan_mask = 16'h00FF; multiplicity = 5'd1;
    coax_in = 16'h0200;
    tick(2);
    coax_in = '0;
    run(8, cnt, first);
    n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL mask_pulses: got %0d want 0", cnt); end
    chan_mask = 16'hFFFF; multiplicity = 5'd17;
    coax_in = 16'hFFFF;
    run(12, cnt, first);
    n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL m17_pulses: got %0d want 0", cnt); end
    n_cmp++; if (trig_count !== 32'd4 || veto_count !== 32'd1) begin n_err++; $display("FAIL m17_counts: got %0d/%0d want 4/1", trig_count, veto_count); end
    coax_in = '0;
    tick(10);
    multiplicity = 5'd0;
    coax_in = 16'h0004;
    run(8, cnt, first);
    n_cmp++; if (cnt !== 1 || hit_pattern !== 16'h0004) begin n_err++; $display("FAIL m0_as_1: got %0d pulses hit %h want 1 hit 0004", cnt, hit_pattern); end
    coax_in = '0;
    tick(5);
    multiplicity = 5'd2; coinc_window = 8'd0;
    coax_in = 16'h0001;
    tick(1);
    coax_in = 16'h0003;
    run(8, cnt, first);
    n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL win0_pulses: got %0d want 0", cnt); end
    coax_in = '0;
    tick(5);
  endtask

  task automatic test_reset_mid;
    multiplicity = 5'd3; coinc_window = 8'd10;
    coax_in = 16'h0003;
    tick(4);
    nrst = 1'b0;
    tick(1);
    nrst = 1'b1;
    tick(2);
    coax_in = 16'h0007;
    run(20, cnt, first);
    n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL rstmid_pulses: got %0d want 0", cnt); end
    n_cmp++; if (trig_count !== 32'd0 || veto_count !== 32'd0) begin n_err++; $display("FAIL rstmid_counts: got %0d/%0d want 0/0", trig_count, veto_count); end
    n_cmp++; if (hit_pattern !== 16'h0) begin n_err++; $display("FAIL rstmid_hit: got %h want 0000", hit_pattern); end
    coax_in = '0;
    tick(3);
  endtask

  initial begin
    test_reset;
    test_single;
    test_window;
    test_busy;
    test_held;
    test_mask;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
